// File: rtl/delay_est_pkg.sv
// Shared types for the delay_est cross-correlation lag estimator:
// FSM state encoding and the accumulator width rule.
package delay_est_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_MAC  = 3'd2,
        ST_SCAN = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // A full-scale 32-bit product summed over 2^win_log2 samples needs win_log2 extra bits.
    function automatic int acc_width(input int win_log2);
        return 32 + win_log2;
    endfunction

endpackage

// File: rtl/delay_est_corr_mac.sv
// corr_mac: registered 16x16 signed multiply followed by an accumulator add
// whose old-value operand can be replaced by zero (first sample of a window).
module corr_mac
    import delay_est_pkg::*;
#(
    parameter int ACC_W = acc_width(8)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue,
    input  logic                    clr_in,
    input  logic signed [15:0]      a,
    input  logic signed [15:0]      b,
    input  logic signed [ACC_W-1:0] acc_in,
    output logic signed [ACC_W-1:0] sum,
    output logic                    wr
);
    logic signed [31:0]      prod_reg;
    logic                    clr_reg;
    logic                    wr_reg;
    logic signed [ACC_W-1:0] base;

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_reg <= '0;
            clr_reg  <= 1'b0;
            wr_reg   <= 1'b0;
        end else begin
            prod_reg <= a * b;
            clr_reg  <= clr_in;
            wr_reg   <= issue;
        end
    end

    assign base = clr_reg ? '0 : acc_in;
    assign sum  = base + ACC_W'(prod_reg);
    assign wr   = wr_reg;

endmodule

// File: rtl/delay_est.sv
// delay_est: cross-correlation lag estimator producing the delay-line sel code.
// Build option DELAY_EST_CONT_EN: after each estimate the next window starts without start.
module delay_est
    import delay_est_pkg::*;
#(
    parameter int N        = 4,
    parameter int L        = 16,
    parameter int WIN_LOG2 = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic signed [15:0]                    ref_in,
    input  logic signed [15:0]                    sig_in,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic                                  busy,
    output logic [N-1:0]                          sel,
    output logic signed [acc_width(WIN_LOG2)-1:0] peak,
    output logic                                  sel_valid
);
    localparam int           ACC_W  = acc_width(WIN_LOG2);
    localparam logic [N-1:0] K_LAST = N'(L - 1);
`ifdef DELAY_EST_CONT_EN
    localparam logic CONT_EN = 1'b1;
`else
    localparam logic CONT_EN = 1'b0;
`endif

    state_t                  state_reg, state_next;
    logic [N-1:0]            k_reg, wr_idx_reg, best_k_reg, sel_reg;
    logic [WIN_LOG2-1:0]     cnt_reg;
    logic signed [15:0]      sig_reg, ref_reg;
    logic signed [ACC_W-1:0] best_reg, peak_reg, mac_sum, scan_val;
    logic                    busy_reg, sel_valid_reg;
    logic                    last_k, mac_issue, mac_wr, shift;
    logic signed [15:0]      hist_w [L];
    logic signed [ACC_W-1:0] acc_w  [L];

    assign last_k    = (k_reg == K_LAST);
    assign mac_issue = (state_reg == ST_MAC);
    assign shift     = mac_issue && last_k;
    assign scan_val  = acc_w[k_reg];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_WAIT;
            ST_WAIT: if (in_valid) state_next = ST_MAC;
            ST_MAC:  if (last_k) state_next = (cnt_reg == '1) ? ST_SCAN : ST_WAIT;
            ST_SCAN: if (last_k) state_next = ST_DONE;
            ST_DONE: state_next = CONT_EN ? ST_WAIT : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            k_reg         <= '0;
            wr_idx_reg    <= '0;
            cnt_reg       <= '0;
            sig_reg       <= '0;
            ref_reg       <= '0;
            best_reg      <= '0;
            best_k_reg    <= '0;
            busy_reg      <= 1'b0;
            sel_reg       <= '0;
            peak_reg      <= '0;
            sel_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            busy_reg      <= (state_next != ST_IDLE);
            sel_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: if (start) cnt_reg <= '0;
                ST_WAIT: begin
                    if (in_valid) begin
                        sig_reg <= sig_in;
                        ref_reg <= ref_in;
                    end
                end
                ST_MAC: begin
                    wr_idx_reg <= k_reg;
                    k_reg      <= last_k ? '0 : k_reg + 1'b1;
                    if (last_k) cnt_reg <= cnt_reg + 1'b1;
                end
                ST_SCAN: begin
                    k_reg <= last_k ? '0 : k_reg + 1'b1;
                    // Strict compare keeps the earliest lag on ties.
                    if (k_reg == '0 || scan_val > best_reg) begin
                        best_reg   <= scan_val;
                        best_k_reg <= k_reg;
                    end
                end
                ST_DONE: begin
                    sel_reg       <= best_k_reg;
                    peak_reg      <= best_reg;
                    sel_valid_reg <= 1'b1;
                    cnt_reg       <= '0;
                end
                default: ;
            endcase
        end
    end

    // Product is registered, so each accumulator write lands one cycle after its lag was issued.
    corr_mac #(.ACC_W(ACC_W)) u_mac (
        .clk    (clk),
        .rst    (rst),
        .issue  (mac_issue),
        .clr_in (cnt_reg == '0),
        .a      (hist_w[k_reg]),
        .b      (sig_reg),
        .acc_in (acc_w[wr_idx_reg]),
        .sum    (mac_sum),
        .wr     (mac_wr)
    );

    generate
        for (genvar gi = 0; gi < L; gi++) begin : g_lag
            logic signed [15:0]      hist_q, hist_src;
            logic signed [ACC_W-1:0] acc_q;

            if (gi == 0) begin : g_head
                assign hist_src = ref_reg;
            end else begin : g_tail
                assign hist_src = hist_w[gi-1];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    hist_q <= '0;
                    acc_q  <= '0;
                end else begin
                    if (shift) hist_q <= hist_src;
                    if (mac_wr && wr_idx_reg == N'(gi)) acc_q <= mac_sum;
                end
            end

            assign hist_w[gi] = hist_q;
            assign acc_w[gi]  = acc_q;
        end
    endgenerate

    assign in_ready  = (state_reg == ST_WAIT);
    assign busy      = busy_reg;
    assign sel       = sel_reg;
    assign peak      = peak_reg;
    assign sel_valid = sel_valid_reg;

endmodule

// File: tb/tb_delay_est.sv
// Directed bench for delay_est: known-delay streams, degenerate data, reset abort
// and handshake timing, each step compared against hand-derived values.
module tb_delay_est;
    localparam int N        = 4;
    localparam int L        = 16;
    localparam int WIN_LOG2 = 8;
    localparam int ACC_W    = 32 + WIN_LOG2;
    localparam int WIN      = 1 << WIN_LOG2;

    logic                    clk = 1'b0;
    logic                    rst, start, in_valid;
    logic signed [15:0]      ref_in, sig_in;
    logic                    in_ready, busy, sel_valid;
    logic [N-1:0]            sel;
    logic signed [ACC_W-1:0] peak;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_pulse = 0;
    int last_acc_cyc = 0;
    // Reference history as the delay line sees it: hist[k] is the ref k+1 acceptances ago.
    logic signed [15:0] hist [L];

    delay_est #(.N(N), .L(L), .WIN_LOG2(WIN_LOG2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ref_in    (ref_in),
        .sig_in    (sig_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .busy      (busy),
        .sel       (sel),
        .peak      (peak),
        .sel_valid (sel_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && in_ready) n_acc <= n_acc + 1;
        if (sel_valid) n_pulse <= n_pulse + 1;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hist();
        for (int k = 0; k < L; k++) hist[k] = 16'sd0;
    endtask

    // Present a pair, hold in_valid until in_ready, then let the next edge accept it.
    task automatic send_pair(input logic signed [15:0] r, input logic signed [15:0] s,
                             output int waited);
        ref_in   = r;
        sig_in   = s;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 100) begin
            tick();
            waited++;
        end
        if (!in_ready) check("accept_timeout", longint'(in_ready), 1);
        tick();
        for (int k = L - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = r;
        last_acc_cyc = cyc;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_rise", longint'(busy), 1);
        check("in_ready_wait", longint'(in_ready), 1);
    endtask

    // kind 0: random ref, sig = delay-line tap d; kind 1: all zero; kind 2: all -32768.
    task automatic run_window(input int kind, input int d, output longint pk);
        int waited, bad_gaps, acc0, pulse0, lat;
        logic signed [15:0] r, s;
        pk = 0;
        bad_gaps = 0;
        acc0 = n_acc;
        pulse0 = n_pulse;
        for (int i = 0; i < WIN; i++) begin
            case (kind)
                0:       r = 16'($urandom);
                1:       r = 16'sd0;
                default: r = 16'sh8000;
            endcase
            s = (kind == 0) ? hist[d] : r;
            send_pair(r, s, waited);
            if (i > 0 && waited != L) bad_gaps++;
            pk += longint'(s) * longint'(s);
        end
        check("gap_17", longint'(bad_gaps), 0);
        lat = 0;
        while (!sel_valid && lat < 200) begin
            tick();
            lat++;
        end
        check("sel_valid_seen", longint'(sel_valid), 1);
        check("latency", longint'(cyc - last_acc_cyc), 2 * L + 1);
`ifdef DELAY_EST_CONT_EN
        in_valid = 1'b0;
        check("busy_at_done", longint'(busy), 1);
`else
        check("busy_at_done", longint'(busy), 0);
`endif
        tick();
        check("sel_valid_pulse", longint'(sel_valid), 0);
        check("pulse_count", longint'(n_pulse - pulse0), 1);
`ifndef DELAY_EST_CONT_EN
        repeat (20) tick();
        check("in_ready_idle", longint'(in_ready), 0);
        in_valid = 1'b0;
`endif
        check("accept_count", longint'(n_acc - acc0), WIN);
    endtask

    initial begin
        logic signed [15:0] r, s;
        int waited;
        longint pk;

        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        ref_in = 16'sd0;
        sig_in = 16'sd0;
        clear_hist();
        repeat (3) tick();
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_sel", longint'(sel), 0);
        check("rst_peak", longint'(peak), 0);
        check("rst_sel_valid", longint'(sel_valid), 0);
        rst = 1'b0;
        tick();

`ifdef DELAY_EST_CONT_EN
        do_start();
        run_window(0, 5, pk);
        check("cont_sel_5", longint'(sel), 5);
        check("cont_peak_5", longint'(peak), pk);
        run_window(0, 9, pk);
        check("cont_sel_9", longint'(sel), 9);
        check("cont_peak_9", longint'(peak), pk);
        check("cont_busy", longint'(busy), 1);
`else
        // Delay-5 stream with in_valid held high throughout.
        do_start();
        run_window(0, 5, pk);
        check("delay5_sel", longint'(sel), 5);
        check("delay5_peak", longint'(peak), pk);

        // Abort with rst during the MAC phase of sample 100.
        do_start();
        for (int i = 0; i <= 100; i++) begin
            r = 16'($urandom);
            s = hist[7];
            send_pair(r, s, waited);
        end
        repeat (3) tick();
        check("mid_mac_not_ready", longint'(in_ready), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_hist();
        check("abort_in_ready", longint'(in_ready), 0);
        check("abort_busy", longint'(busy), 0);
        check("abort_sel", longint'(sel), 0);
        check("abort_peak", longint'(peak), 0);
        check("abort_sel_valid", longint'(sel_valid), 0);
        tick();
        check("abort_idle", longint'(in_ready), 0);
        in_valid = 1'b0;

        do_start();
        run_window(0, 7, pk);
        check("delay7_sel", longint'(sel), 7);
        check("delay7_peak", longint'(peak), pk);

        // All-zero data: every lag ties at zero, earliest lag wins.
        do_start();
        run_window(1, 0, pk);
        check("zero_sel", longint'(sel), 0);
        check("zero_peak", longint'(peak), 0);

        // Full-scale negative data after reset: lag 0 misses only the first product.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_hist();
        tick();
        do_start();
        run_window(2, 0, pk);
        check("minval_sel", longint'(sel), 0);
        check("minval_peak", longint'(peak), 64'sd273804165120);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/delay_est.md
# delay_est

Cross-correlation delay estimator for the audio path. It accepts paired 16-bit signed samples: a reference stream and a delayed observation of that stream. Over a programmable window it finds the lag that best aligns them and outputs that lag as a `sel` value. This is the control-side counterpart of the programmable delay line: the estimator produces the `sel` code that the delay line consumes, so that the delay line applied to the reference matches the observed signal.

## Interface
- `N`, default 4: width of `sel`; the number of lags is `L`.
- `L`, default 16: number of candidate lags, 0..L-1; L ≤ 2^N.
- `WIN_LOG2`, default 8: the estimation window is 2^WIN_LOG2 accepted samples.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: one-cycle request to begin an estimate; honoured only in IDLE.
- `ref_in` input 16: signed reference sample.
- `sig_in` input 16: signed observed sample.
- `in_valid` input 1: the sample pair is valid.
- `in_ready` output 1: the block can accept a pair this cycle.
- `busy` output 1: high in every state except IDLE.
- `sel` output N: estimated lag; holds its value until the next estimate completes.
- `peak` output 32+WIN_LOG2: signed correlation value at `sel`.
- `sel_valid` output 1: one-cycle pulse when `sel` and `peak` update.

## Operation
- Reference history: `h[0..L-1]`, 16-bit signed, with `h[k]` = the reference sample k+1 acceptances ago. On acceptance, all products use the pre-shift history. Then `h[0]` <= `ref_in` and the rest shift. Lag k therefore corresponds to delay-line `sel = k`.
- Accumulators: `acc[0..L-1]`, signed, ACC_W = 32+WIN_LOG2 bits. Products are full 32-bit signed values (`-32768*-32768 = 2^30` fits). No saturation is needed.
- FSM states and transitions:
  - IDLE: `in_ready`=0. `start` → WAIT; clears the sample counter.
  - WAIT: `in_ready`=1. On `in_valid && in_ready`, capture `sig_in` and go to MAC.
  - MAC: L cycles, lag index k = 0..L-1, one multiply-accumulate per cycle: `acc[k] <= (cnt==0 ? 0 : acc[k]) + h[k]*sig`. This is the first-sample overwrite, so no separate clear state exists. At k = L-1 the history shifts, `cnt` increments, and the FSM goes to SCAN if `cnt` was 2^WIN_LOG2-1, otherwise back to WAIT.
  - SCAN: L cycles, running argmax over `acc[0..L-1]` using a strict greater-than comparison. On ties the smallest k wins.
  - DONE: one cycle. `sel`/`peak` load from the argmax, `sel_valid`=1, then go to IDLE (see Configuration).
- `start` outside IDLE is ignored. `in_valid` outside WAIT is ignored and not buffered; upstream must hold the pair until `in_ready` is seen.
- `rst` in any state returns the FSM to IDLE, zeroes the history, accumulators, counter and all outputs, and aborts any estimate in progress.

## Timing
- Reset values: `in_ready`=0, `busy`=0, `sel`=0, `peak`=0, `sel_valid`=0.
- Maximum throughput is one accepted pair per L+1 cycles: 1 WAIT cycle plus L MAC cycles.
- Latency: `sel_valid` rises in the cycle 2L+1 clocks after the edge that accepts the final window sample (L MAC cycles, L SCAN cycles, DONE). `sel`/`peak` are valid from that same cycle.
- `busy` is registered. It rises the cycle after `start` and falls the cycle after DONE.

## Configuration
- `DELAY_EST_CONT_EN` defined: after DONE the FSM goes directly to WAIT with `cnt`=0 and starts the next window without `start`. `busy` stays high; the only way to stop is `rst`.
- Not defined: DONE → IDLE, and each estimate requires `start`.

## Structure
- `delay_est_pkg`: the FSM state enum (IDLE, WAIT, MAC, SCAN, DONE) and an `ACC_W`-style width function of `WIN_LOG2`.
- One sub-module, `corr_mac`: a registered 16×16 signed multiply plus an ACC_W-bit add with an overwrite select. The FSM, history, accumulator array and argmax stay in `delay_est`.

## Test plan
Defaults L=16, WIN_LOG2=8.
- Random `ref`, `sig` = `ref` delayed 5 accepted samples, `start` → `sel`=5, `sel_valid` pulses once.
- `ref` = `sig` = 0 for 256 samples → `sel`=0 (tie-break), `peak`=0.
- After reset, `ref` = `sig` = -32768 for 256 samples → `sel`=0, `peak` = 255·2^30 (checks width and the zeroed history).
- `in_valid` held high continuously → `in_ready` high one cycle in every 17. Exactly 256 acceptances occur. `sel_valid` comes 33 clocks after the last acceptance.
- `rst` pulsed mid-MAC at sample 100 → the next cycle all outputs are 0 and the FSM is in IDLE. A new `start` plus delay-7 data → `sel`=7.
- With `DELAY_EST_CONT_EN`, delay 5 then delay 9 data and a single `start` → two `sel_valid` pulses with `sel`=5, then `sel`=9.
